// File: rtl/tim_etb_trig_route_if.sv
// APB slave bus for the ETB trigger-routing stage; clock and reset stay outside.
interface tim_etb_trig_route_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/tim_etb_trig_route.sv
// Routes timer/software trigger events through two pending-event channels
// onto single-cycle start/stop pulses for the two timers.
module tim_etb_trig_route #(
  parameter int CNT_W = 2
) (
  input  logic                 pclk,
  input  logic                 preset,
  tim_etb_trig_route_if.slave  apb,
  input  logic                 tim1_etb_trig,
  input  logic                 tim2_etb_trig,
  output logic                 etb_tim1_trig_en_on,
  output logic                 etb_tim1_trig_en_off,
  output logic                 etb_tim2_trig_en_on,
  output logic                 etb_tim2_trig_en_off,
  output logic                 ovf_intr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             apb_wr;
  logic [1:0]       reg_idx;
  logic [1:0]       en, dst, act;
  logic [1:0]       src [2];
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       ovf;
  logic [1:0]       t1_pipe, t2_pipe;
  logic             t1_ev, t2_ev;
  logic [1:0]       cfg_wr, sw_ev, ev, req, grant, keep, ovf_set, w1c;
  logic [3:0]       cnt0_ext, cnt1_ext;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign apb_wr      = apb.psel & apb.penable & apb.pwrite;
  assign reg_idx     = apb.paddr[3:2];
  assign unused_bits = ^{apb.pwdata[31:5], apb.paddr[1:0]};

  // Inputs are registered first and the edge is taken between the two
  // registered copies, giving a 2-cycle source-to-pulse latency.
  assign t1_ev = t1_pipe[0] & ~t1_pipe[1];
  assign t2_ev = t2_pipe[0] & ~t2_pipe[1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cfg_wr[n] = apb_wr && (reg_idx == 2'(n));
      sw_ev[n]  = apb_wr && (reg_idx == 2'd2) && apb.pwdata[n];
      keep[n]   = en[n] && !(cfg_wr[n] && !apb.pwdata[0]);
      req[n]    = (cnt[n] != '0);
      case (src[n])
        2'd0:    ev[n] = t1_ev;
        2'd1:    ev[n] = t2_ev;
        2'd2:    ev[n] = sw_ev[n];
        default: ev[n] = 1'b0;
      endcase
    end
    grant[0] = req[0];
    grant[1] = req[1] & ~(req[0] & (dst[0] == dst[1]));
    for (int n = 0; n < 2; n++) begin
      ovf_set[n] = keep[n] && ev[n] && !grant[n] && (cnt[n] == CNT_MAX);
    end
    w1c = (apb_wr && (reg_idx == 2'd3)) ? apb.pwdata[1:0] : 2'b00;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      t1_pipe <= '0;
      t2_pipe <= '0;
    end else begin
      t1_pipe <= {t1_pipe[0], tim1_etb_trig};
      t2_pipe <= {t2_pipe[0], tim2_etb_trig};
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      en  <= '0;
      dst <= '0;
      act <= '0;
      for (int n = 0; n < 2; n++) src[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (cfg_wr[n]) begin
          en[n]  <= apb.pwdata[0];
          src[n] <= apb.pwdata[2:1];
          dst[n] <= apb.pwdata[3];
          act[n] <= apb.pwdata[4];
        end
      end
    end
  end

  // A simultaneous event and grant leave the count unchanged; a full
  // counter drops the event and flags overflow instead.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf <= '0;
      for (int n = 0; n < 2; n++) cnt[n] <= '0;
    end else begin
      ovf <= (ovf & ~w1c) | ovf_set;
      for (int n = 0; n < 2; n++) begin
        if (!keep[n])
          cnt[n] <= '0;
        else if (ev[n] && !grant[n] && (cnt[n] != CNT_MAX))
          cnt[n] <= cnt[n] + CNT_W'(1);
        else if (!ev[n] && grant[n])
          cnt[n] <= cnt[n] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      etb_tim1_trig_en_on  <= 1'b0;
      etb_tim1_trig_en_off <= 1'b0;
      etb_tim2_trig_en_on  <= 1'b0;
      etb_tim2_trig_en_off <= 1'b0;
    end else begin
      etb_tim1_trig_en_on  <= (grant[0] & ~dst[0] & ~act[0]) | (grant[1] & ~dst[1] & ~act[1]);
      etb_tim1_trig_en_off <= (grant[0] & ~dst[0] &  act[0]) | (grant[1] & ~dst[1] &  act[1]);
      etb_tim2_trig_en_on  <= (grant[0] &  dst[0] & ~act[0]) | (grant[1] &  dst[1] & ~act[1]);
      etb_tim2_trig_en_off <= (grant[0] &  dst[0] &  act[0]) | (grant[1] &  dst[1] &  act[1]);
    end
  end

  assign cnt0_ext = 4'(cnt[0]);
  assign cnt1_ext = 4'(cnt[1]);

  always_comb begin
    rd_data = '0;
    if (apb.psel && !apb.pwrite) begin
      case (reg_idx)
        2'd0:    rd_data = {27'b0, act[0], dst[0], src[0], en[0]};
        2'd1:    rd_data = {27'b0, act[1], dst[1], src[1], en[1]};
        2'd3:    rd_data = {20'b0, cnt1_ext, cnt0_ext, 2'b00, ovf};
        default: rd_data = '0;
      endcase
    end
  end

  assign apb.prdata = rd_data;
  assign ovf_intr   = |ovf;

endmodule

// File: tb/tb_tim_etb_trig_route.sv
// Directed plus randomized bench for tim_etb_trig_route against a cycle-level
// reference model of the routing rules.
module tb_tim_etb_trig_route;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic pclk = 1'b0;
  logic preset;
  logic tim1, tim2;
  logic t1_on, t1_off, t2_on, t2_off, ovf_intr;

  tim_etb_trig_route_if bus ();

  tim_etb_trig_route #(.CNT_W(CNT_W)) dut (
    .pclk                 (pclk),
    .preset               (preset),
    .apb                  (bus),
    .tim1_etb_trig        (tim1),
    .tim2_etb_trig        (tim2),
    .etb_tim1_trig_en_on  (t1_on),
    .etb_tim1_trig_en_off (t1_off),
    .etb_tim2_trig_en_on  (t2_on),
    .etb_tim2_trig_en_off (t2_off),
    .ovf_intr             (ovf_intr)
  );

  always #5 pclk = ~pclk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_cnt [2];
  bit m_ovf [2];
  bit m_en  [2];
  int m_src [2];
  bit m_dst [2];
  bit m_act [2];
  bit m_t1q, m_t1qq, m_t2q, m_t2qq;
  bit m_out [4];   // tim1 on, tim1 off, tim2 on, tim2 off

  int seen [4];
  int seen_both_t1;
  int base [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_prdata();
    int idx;
    if (!(bus.psel && !bus.pwrite)) return 32'd0;
    idx = int'(bus.paddr) / 4;
    if (idx < 2)
      return 32'(m_en[idx] + m_src[idx] * 2 + m_dst[idx] * 8 + m_act[idx] * 16);
    if (idx == 3)
      return 32'(m_ovf[0] + m_ovf[1] * 2 + m_cnt[0] * 16 + m_cnt[1] * 256);
    return 32'd0;
  endfunction

  task automatic model_tick();
    bit wr;
    int idx, c;
    bit ev [2];
    bit g  [2];
    bit set [2];
    if (preset) begin
      for (int n = 0; n < 2; n++) begin
        m_cnt[n] = 0; m_ovf[n] = 0; m_en[n] = 0; m_src[n] = 0; m_dst[n] = 0; m_act[n] = 0;
      end
      for (int k = 0; k < 4; k++) m_out[k] = 0;
      m_t1q = 0; m_t1qq = 0; m_t2q = 0; m_t2qq = 0;
      return;
    end
    wr  = bus.psel && bus.penable && bus.pwrite;
    idx = int'(bus.paddr) / 4;
    for (int n = 0; n < 2; n++) begin
      case (m_src[n])
        0:       ev[n] = m_t1q && !m_t1qq;
        1:       ev[n] = m_t2q && !m_t2qq;
        2:       ev[n] = wr && idx == 2 && bus.pwdata[n];
        default: ev[n] = 0;
      endcase
    end
    g[0] = m_cnt[0] > 0;
    g[1] = m_cnt[1] > 0 && !(m_cnt[0] > 0 && m_dst[0] == m_dst[1]);
    for (int k = 0; k < 4; k++) m_out[k] = 0;
    for (int n = 0; n < 2; n++)
      if (g[n]) m_out[m_dst[n] * 2 + m_act[n]] = 1;
    for (int n = 0; n < 2; n++) begin
      set[n] = 0;
      if (!m_en[n] || (wr && idx == n && !bus.pwdata[0])) begin
        m_cnt[n] = 0;
      end else begin
        c = m_cnt[n] + int'(ev[n]) - int'(g[n]);
        if (c > MAXC) begin
          c = MAXC;
          set[n] = 1;
        end
        m_cnt[n] = c;
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (wr && idx == 3 && bus.pwdata[n]) m_ovf[n] = 0;
      if (set[n]) m_ovf[n] = 1;
      if (wr && idx == n) begin
        m_en[n]  = bus.pwdata[0];
        m_src[n] = int'(bus.pwdata[2:1]);
        m_dst[n] = bus.pwdata[3];
        m_act[n] = bus.pwdata[4];
      end
    end
    m_t1qq = m_t1q; m_t1q = tim1;
    m_t2qq = m_t2q; m_t2q = tim2;
  endtask

  task automatic check_output();
    chk("tim1_on",  32'(t1_on),  32'(m_out[0]));
    chk("tim1_off", 32'(t1_off), 32'(m_out[1]));
    chk("tim2_on",  32'(t2_on),  32'(m_out[2]));
    chk("tim2_off", 32'(t2_off), 32'(m_out[3]));
    chk("ovf_intr", 32'(ovf_intr), 32'(m_ovf[0] | m_ovf[1]));
    chk("prdata",   bus.prdata, exp_prdata());
    seen[0] += int'(t1_on);  seen[1] += int'(t1_off);
    seen[2] += int'(t2_on);  seen[3] += int'(t2_off);
    if (t1_on && t1_off) seen_both_t1++;
  endtask

  task automatic apply_stimulus();
    model_tick();
    @(posedge pclk);
    #1;
    check_output();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus();
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    bus.psel = 1; bus.penable = 1; bus.pwrite = 1; bus.paddr = addr; bus.pwdata = data;
    apply_stimulus();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic apb_read(input logic [3:0] addr);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = addr;
    #1;
    chk("read", bus.prdata, exp_prdata());
    bus.psel = 0;
  endtask

  task automatic snap();
    for (int k = 0; k < 4; k++) base[k] = seen[k];
  endtask

  initial begin
    int r;
    seen_both_t1 = 0;
    for (int k = 0; k < 4; k++) seen[k] = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    tim1 = 0; tim2 = 0; preset = 1;
    idle(2);
    preset = 0;
    idle(1);
    apb_read(4'h0);
    apb_read(4'hC);

    // single rise held for 5 cycles gives a single tim2 start pulse
    apb_write(4'h0, 32'h09);
    snap();
    tim1 = 1;
    idle(5);
    tim1 = 0;
    idle(4);
    chk("held_level_one_pulse", 32'(seen[2] - base[2]), 32'd1);
    apb_read(4'hC);

    // two channels on tim1 from one tim2 rise: on then off, never together
    apb_write(4'h0, 32'h03);
    apb_write(4'h4, 32'h13);
    snap();
    tim2 = 1;
    idle(1);
    tim2 = 0;
    idle(5);
    chk("shared_on_pulses",  32'(seen[0] - base[0]), 32'd1);
    chk("shared_off_pulses", 32'(seen[1] - base[1]), 32'd1);
    chk("never_simultaneous", 32'(seen_both_t1), 32'd0);

    // ch1 blocked behind ch0 while sw triggers saturate it
    apb_write(4'h0, 32'h05);
    apb_write(4'h4, 32'h15);
    snap();
    for (int i = 0; i < 4; i++) apb_write(4'h8, 32'h3);
    apb_read(4'hC);
    chk("ovf_set", 32'(ovf_intr), 32'd1);
    apb_write(4'hC, 32'h2);
    apb_read(4'hC);
    idle(6);
    chk("drained_off_pulses", 32'(seen[1] - base[1]), 32'd3);

    // event and grant together at count 1
    apb_write(4'h4, 32'h00);
    apb_write(4'h8, 32'h1);
    apb_write(4'h8, 32'h1);
    apb_read(4'hC);
    idle(3);

    // disabling a channel with 2 pending discards them
    apb_write(4'h4, 32'h15);
    apb_write(4'h8, 32'h3);
    apb_write(4'h8, 32'h3);
    apb_read(4'hC);
    apb_write(4'h4, 32'h14);
    apb_read(4'hC);
    snap();
    idle(5);
    chk("disabled_no_pulses", 32'(seen[1] - base[1]), 32'd0);

    // reset while pulses are pending
    apb_write(4'h4, 32'h15);
    for (int i = 0; i < 3; i++) apb_write(4'h8, 32'h3);
    preset = 1;
    idle(1);
    preset = 0;
    apb_read(4'h0);
    apb_read(4'hC);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      tim1 = 1'($urandom);
      tim2 = 1'($urandom);
      r = int'($urandom_range(0, 9));
      bus.paddr  = 4'($urandom);
      bus.pwdata = $urandom;
      if (r == 0) begin
        bus.pwdata[2] = bus.pwdata[2] | bus.pwdata[1];
        bus.psel = 1; bus.penable = 1; bus.pwrite = 1;
      end else if (r == 1) begin
        bus.psel = 1; bus.penable = 1; bus.pwrite = 0;
      end else begin
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
      end
      preset = ($urandom_range(0, 299) == 0);
      apply_stimulus();
    end
    preset = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
